// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO result registers.
// Define MULT_DIV_UNIT_DIV_EN to build in the restoring-divide datapath.
module mult_div_unit #(
    parameter int bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [bit_size-1:0] src_a,
    input  logic [bit_size-1:0] src_b,
    input  logic                mthi,
    input  logic                mtlo,
    output logic                busy,
    output logic                done,
    output logic [bit_size-1:0] hi,
    output logic [bit_size-1:0] lo
);
    localparam int W  = bit_size;
    localparam int CW = $clog2(bit_size + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   m_q, m_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
`ifdef MULT_DIV_UNIT_DIV_EN
    logic           div_q, div_d;
    logic           rneg_q, rneg_d;
    logic           dz_q, dz_d;
`endif

    logic           sa, sb;
    logic [W-1:0]   abs_a, abs_b;
    logic [W-1:0]   addend;
    logic [W:0]     msum;
    logic [2*W-1:0] mul_next;
    logic [2*W-1:0] prod_neg;
`ifdef MULT_DIV_UNIT_DIV_EN
    logic [W:0]     dsh, ddif;
    logic [W-1:0]   rem_new;
    logic [W-1:0]   q_fix, r_fix;
    logic [2*W-1:0] div_next;
`endif

    // Operand conditioning: magnitudes for signed ops, raw values otherwise
    always_comb begin
        sa    = op[0] & src_a[W-1];
        sb    = op[0] & src_b[W-1];
        abs_a = sa ? ('0 - src_a) : src_a;
        abs_b = sb ? ('0 - src_b) : src_b;
    end

    // One shift-add multiply step; prod holds {partial, multiplier}
    always_comb begin
        addend   = prod_q[0] ? m_q : '0;
        msum     = {1'b0, prod_q[2*W-1:W]} + {1'b0, addend};
        mul_next = {msum, prod_q[W-1:1]};
        prod_neg = '0 - prod_q;
    end

`ifdef MULT_DIV_UNIT_DIV_EN
    // One restoring-divide step; prod holds {remainder, quotient}
    always_comb begin
        dsh      = {prod_q[2*W-1:W], prod_q[W-1]};
        ddif     = dsh - {1'b0, m_q};
        rem_new  = ddif[W] ? dsh[W-1:0] : ddif[W-1:0];
        div_next = {rem_new, prod_q[W-2:0], ~ddif[W]};
        if (dz_q)
            q_fix = '1;
        else
            q_fix = neg_q ? ('0 - prod_q[W-1:0]) : prod_q[W-1:0];
        r_fix = rneg_q ? ('0 - prod_q[2*W-1:W]) : prod_q[2*W-1:W];
    end
`endif

    // Next-state, datapath and HI/LO update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULT_DIV_UNIT_DIV_EN
        div_d   = div_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
`ifdef MULT_DIV_UNIT_DIV_EN
                    state_d = CALC;
                    cnt_d   = '0;
                    neg_d   = sa ^ sb;
                    div_d   = op[1];
                    rneg_d  = sa;
                    dz_d    = (src_b == '0);
                    if (op[1]) begin
                        prod_d = {{W{1'b0}}, abs_a};
                        m_d    = abs_b;
                    end else begin
                        prod_d = {{W{1'b0}}, abs_b};
                        m_d    = abs_a;
                    end
`else
                    if (op[1]) begin
                        // No divider: finish at once, HI/LO untouched
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                        cnt_d   = '0;
                        neg_d   = sa ^ sb;
                        prod_d  = {{W{1'b0}}, abs_b};
                        m_d     = abs_a;
                    end
`endif
                end else begin
                    if (mthi)
                        hi_d = src_a;
                    if (mtlo)
                        lo_d = src_a;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
`ifdef MULT_DIV_UNIT_DIV_EN
                prod_d = div_q ? div_next : mul_next;
`else
                prod_d = mul_next;
`endif
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                state_d = DONE;
`ifdef MULT_DIV_UNIT_DIV_EN
                if (div_q) begin
                    hi_d = r_fix;
                    lo_d = q_fix;
                end else begin
                    {hi_d, lo_d} = neg_q ? prod_neg : prod_q;
                end
`else
                {hi_d, lo_d} = neg_q ? prod_neg : prod_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULT_DIV_UNIT_DIV_EN
            div_q   <= div_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, random ops vs arithmetic model,
// and hand sequences for reset abort, busy-start and move corners.
module tb_mult_div_unit;
    localparam int W = 32;

`ifdef MULT_DIV_UNIT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.bit_size(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .src_a(src_a),
        .src_b(src_b),
        .mthi (mthi),
        .mtlo (mtlo),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] prev);
        longint p;
        int     sa, sb;
        if (o[1] && !DIV_EN)
            return prev;
        case (o)
            2'b00: return {32'b0, a} * {32'b0, b};
            2'b01: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            2'b10: begin
                if (b == 0)
                    return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                sa = a;
                sb = b;
                if (b == 0)
                    return {a, 32'hFFFFFFFF};
                if (sa == int'(32'h80000000) && sb == -1)
                    return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic mh,
                            input logic ml);
        @(negedge clk);
        op = o; src_a = a; src_b = b;
        start = 1'b1; mthi = mh; mtlo = ml;
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < 100) begin
            if (busy)
                bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done timeout: got done=%0b required 1", done);
        end
    endtask

    task automatic move(input logic mh, input logic ml, input logic [31:0] v);
        @(negedge clk);
        src_a = v; mthi = mh; mtlo = ml;
        @(posedge clk);
        #1;
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] mst, exp;
        logic [31:0] ndh, ndl, ra, rb;
        logic [1:0]  ro;
        int          lat, bc, exp_lat;
        bit          seen;

        rst = 1'b1; start = 1'b0; op = 2'b00;
        src_a = '0; src_b = '0; mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        rst = 1'b0;

        move(1'b1, 1'b0, 32'h1234);
        chk("mthi idle hi", hi, 32'h1234);
        chk("mthi idle lo", lo, 0);

        ndh = 32'hFFFFFFFF;
        ndl = 32'hFFFFFFFA;
        tbl[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
        tbl[1]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
        tbl[2]  = '{2'b01, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[3]  = '{2'b01, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[4]  = '{2'b11, 32'hFFFFFFF9, 32'h2,
                    DIV_EN ? 32'hFFFFFFFF : ndh, DIV_EN ? 32'hFFFFFFFD : ndl};
        tbl[5]  = '{2'b10, 32'h7, 32'h0,
                    DIV_EN ? 32'h7 : ndh, DIV_EN ? 32'hFFFFFFFF : ndl};
        tbl[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF,
                    DIV_EN ? 32'h0 : ndh, DIV_EN ? 32'h80000000 : ndl};
        tbl[7]  = '{2'b10, 32'd10, 32'd3,
                    DIV_EN ? 32'h1 : ndh, DIV_EN ? 32'h3 : ndl};
        tbl[8]  = '{2'b11, 32'h7, 32'hFFFFFFFE,
                    DIV_EN ? 32'h1 : ndh, DIV_EN ? 32'hFFFFFFFD : ndl};
        tbl[9]  = '{2'b11, 32'hFFFFFFF8, 32'hFFFFFFFD,
                    DIV_EN ? 32'hFFFFFFFE : ndh, DIV_EN ? 32'h2 : ndl};
        tbl[10] = '{2'b11, 32'hFFFFFFFB, 32'h0,
                    DIV_EN ? 32'hFFFFFFFB : ndh, DIV_EN ? 32'hFFFFFFFF : ndl};

        foreach (tbl[i]) begin
            exp_lat = (DIV_EN || !tbl[i].op[1]) ? 33 : 0;
            start_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
            wait_done(lat, bc);
            chk($sformatf("tbl%0d latency", i), lat, exp_lat);
            chk($sformatf("tbl%0d busy cycles", i), bc, exp_lat);
            chk($sformatf("tbl%0d hi", i), hi, tbl[i].hi);
            chk($sformatf("tbl%0d lo", i), lo, tbl[i].lo);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d done pulse", i), done, 0);
        end
        mst = {tbl[10].hi, tbl[10].lo};

        for (int n = 0; n < 30; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            exp = model(ro, ra, rb, mst);
            exp_lat = (DIV_EN || !ro[1]) ? 33 : 0;
            start_op(ro, ra, rb, 1'b0, 1'b0);
            wait_done(lat, bc);
            chk($sformatf("rnd%0d op%0d %h %h latency", n, ro, ra, rb),
                lat, exp_lat);
            chk($sformatf("rnd%0d op%0d %h %h hilo", n, ro, ra, rb),
                {hi, lo}, exp);
            mst = exp;
        end

        move(1'b0, 1'b1, 32'hAAAA);
        chk("mtlo idle lo", lo, 32'hAAAA);
        start_op(2'b00, 32'd5, 32'd6, 1'b0, 1'b1);
        chk("start beats mtlo", lo, 32'hAAAA);
        wait_done(lat, bc);
        chk("start+mtlo lo", lo, 32'd30);
        chk("start+mtlo hi", hi, 32'd0);

        start_op(2'b00, 32'd5, 32'd6, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        op = 2'b01; src_a = 32'd7; src_b = 32'd9;
        start = 1'b1; mthi = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0;
        chk("mthi while busy", hi, 32'd0);
        chk("busy after restart", busy, 1);
        wait_done(lat, bc);
        chk("busy start latency", lat + 6, 33);
        chk("busy start lo", lo, 32'd30);
        chk("busy start hi", hi, 32'd0);

        start_op(2'b00, 32'd5, 32'd6, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort hi", hi, 0);
        chk("abort lo", lo, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || hi != 0 || lo != 0)
                seen = 1'b1;
        end
        chk("abort no done or write", seen, 0);

        move(1'b1, 1'b1, 32'h55);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 2'b00;
        src_a = 32'd3; src_b = 32'd3; mthi = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; mthi = 1'b0;
        chk("rst over start busy", busy, 0);
        chk("rst over mthi hi", hi, 0);

        start_op(2'b00, 32'd3, 32'd4, 1'b0, 1'b0);
        wait_done(lat, bc);
        chk("b2b first lo", lo, 32'd12);
        start_op(2'b01, 32'hFFFFFFFD, 32'd4, 1'b0, 1'b0);
        wait_done(lat, bc);
        chk("b2b latency", lat, 33);
        chk("b2b hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: bit_size, default 32, operand/result width; the unit SHALL support only this one parameter.
REQ-002 clk  in  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst  in  1  synchronous active-high reset, sampled on rising clk.
REQ-004 start  in  1  request operation; SHALL be sampled only in IDLE or DONE.
REQ-005 op  in  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 src_a  in  bit_size  rs operand (regfile read port 1); dividend/multiplicand; MTHI/MTLO data.
REQ-007 src_b  in  bit_size  rt operand (regfile read port 2); divisor/multiplier.
REQ-008 mthi, mtlo  in  1 each  write src_a into hi/lo.
REQ-009 busy  out  1  high while CALC or FIX.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 hi, lo  out  bit_size each  registered result; feed MFHI/MFLO writeback to regfile.

Function
REQ-012 FSM states SHALL be IDLE, CALC, FIX, DONE; DONE->IDLE unconditionally unless a new start is accepted.
REQ-013 Accepted start at edge t0 SHALL latch |src_a|, |src_b| (absolute value for signed ops), result sign(s), op; state->CALC, busy=1.
REQ-014 CALC SHALL run exactly bit_size cycles: multiply = 1 shift-add step/cycle, divide = 1 restoring-subtract step/cycle, driven by a cycle counter.
REQ-015 At edge t0+bit_size state->FIX; at edge t0+bit_size+1, sign correction applied, hi/lo written, state->DONE.
REQ-016 done SHALL be 1 only in DONE, busy 0 in DONE; latency start-edge to done = bit_size+1 cycles.
REQ-017 Multiply: {hi,lo} = full 2*bit_size product; signed result is the two's-complement product.
REQ-018 Divide: lo = quotient, hi = remainder; signed quotient truncates toward zero; remainder takes dividend sign.
REQ-019 Divide by zero: lo = all ones, hi = src_a as latched (original signed value), same latency.
REQ-020 Signed overflow (most-negative / -1): lo = most-negative value, hi = 0.
REQ-021 start while busy SHALL be ignored; operands and op SHALL not be re-latched.
REQ-022 mthi/mtlo SHALL write at next edge only in IDLE or DONE with start=0; ignored while busy.
REQ-023 start and mthi/mtlo same cycle: start wins, move ignored.
REQ-024 hi/lo SHALL hold value at all times except REQ-015, REQ-022, reset.

Reset
REQ-025 rst=1 SHALL, at next edge, force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-026 rst mid-CALC/FIX SHALL abort: no hi/lo update, no done pulse.
REQ-027 rst SHALL take priority over start, mthi, mtlo.

Configuration
REQ-028 Macro MULT_DIV_UNIT_DIV_EN compiles in the divide datapath.
REQ-029 Defined: DIVU/DIV per REQ-018..020.
REQ-030 Undefined: start with op[1]=1 SHALL go IDLE->DONE in one cycle, done=1, busy never set, hi/lo unchanged; multiply unaffected.

Verification
REQ-031 MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 MULT 0xFFFFFFFE(-2)*0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=1 for 33 cycles.
REQ-033 DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; without macro DIVU 10/3 -> done next cycle, hi/lo unchanged.
REQ-035 start MULTU 5*6, rst at cycle 10 -> busy=0, hi=lo=0, no done; second start during busy ignored.
REQ-036 mthi 0x1234 in IDLE -> hi=0x1234; mtlo with start same cycle -> lo from multiply only.
